// File: rtl/program_loader.sv
// Byte-stream program loader: assembles little-endian words into instruction memory
// and sequences core reset, run, single-step and halt.
//
// state | meaning
// IDLE  | core halted, waiting for a command byte
// LOAD  | assembling received bytes into words and writing them
// RUN   | core free-running until the pipeline retires a halt
// STEP  | core released for exactly one cycle
// DONE  | core halted after finishing; only a new load is accepted
module program_loader #(
  parameter int          ADDR_WIDTH = 8,
  parameter logic [31:0] END_MARKER = 32'hFFFF_FFFF,
  parameter logic [7:0]  CMD_LOAD   = 8'h4C,
  parameter logic [7:0]  CMD_RUN    = 8'h52,
  parameter logic [7:0]  CMD_STEP   = 8'h53
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  input  logic        i_pipeline_halted,
  output logic        o_write_instruction,
  output logic [31:0] o_instruction,
  output logic [31:0] o_address,
  output logic        o_halt,
  output logic        o_core_reset,
  output logic        o_overflow,
  output logic [2:0]  o_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_RUN  = 3'd2,
    S_STEP = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [1:0]            byte_cnt_q, byte_cnt_d;
  logic [ADDR_WIDTH-3:0] word_cnt_q, word_cnt_d;
  logic [23:0]           part_q, part_d;
  logic                  finish_q, finish_d;
  logic                  write_q, write_d;
  logic [31:0]           instr_q, instr_d;
  logic [31:0]           addr_q, addr_d;
  logic                  halt_q, halt_d;
  logic                  core_reset_q, core_reset_d;
  logic                  overflow_q, overflow_d;
  logic [31:0]           asm_word;
  logic                  start_load;

  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    word_cnt_d   = word_cnt_q;
    part_d       = part_q;
    finish_d     = finish_q;
    write_d      = 1'b0;
    instr_d      = instr_q;
    addr_d       = addr_q;
    core_reset_d = 1'b0;
    overflow_d   = overflow_q;
    asm_word     = {i_rx_data, part_q};
    start_load   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_rx_valid) begin
          if (i_rx_data == CMD_LOAD)      start_load = 1'b1;
          else if (i_rx_data == CMD_RUN)  state_d = S_RUN;
          else if (i_rx_data == CMD_STEP) state_d = S_STEP;
        end
      end
      S_LOAD: begin
        if (finish_q) begin
          // Write cycle of the final word: it ends the load either as the
          // marker or as the last word that fits, which is an overflow.
          state_d    = S_IDLE;
          finish_d   = 1'b0;
          overflow_d = (instr_q != END_MARKER);
        end else if (i_rx_valid) begin
          case (byte_cnt_q)
            2'd0: part_d[7:0]   = i_rx_data;
            2'd1: part_d[15:8]  = i_rx_data;
            2'd2: part_d[23:16] = i_rx_data;
            default: begin
              write_d    = 1'b1;
              instr_d    = asm_word;
              addr_d     = 32'({word_cnt_q, 2'b00});
              word_cnt_d = word_cnt_q + 1'b1;
              part_d     = '0;
              finish_d   = (asm_word == END_MARKER) || (&word_cnt_q);
            end
          endcase
          byte_cnt_d = byte_cnt_q + 2'd1;
        end
      end
      S_RUN: begin
        if (i_pipeline_halted) state_d = S_DONE;
      end
      S_STEP: begin
        state_d = i_pipeline_halted ? S_DONE : S_IDLE;
      end
      S_DONE: begin
        if (i_rx_valid && (i_rx_data == CMD_LOAD)) start_load = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (start_load) begin
      state_d      = S_LOAD;
      core_reset_d = 1'b1;
      word_cnt_d   = '0;
      byte_cnt_d   = '0;
      part_d       = '0;
      finish_d     = 1'b0;
      overflow_d   = 1'b0;
    end

    halt_d = (state_d != S_RUN) && (state_d != S_STEP);
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q      <= S_IDLE;
      byte_cnt_q   <= '0;
      word_cnt_q   <= '0;
      part_q       <= '0;
      finish_q     <= 1'b0;
      write_q      <= 1'b0;
      instr_q      <= '0;
      addr_q       <= '0;
      halt_q       <= 1'b1;
      core_reset_q <= 1'b1;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      word_cnt_q   <= word_cnt_d;
      part_q       <= part_d;
      finish_q     <= finish_d;
      write_q      <= write_d;
      instr_q      <= instr_d;
      addr_q       <= addr_d;
      halt_q       <= halt_d;
      core_reset_q <= core_reset_d;
      overflow_q   <= overflow_d;
    end
  end

  assign o_write_instruction = write_q;
  assign o_instruction       = instr_q;
  assign o_address           = addr_q;
  assign o_halt              = halt_q;
  assign o_core_reset        = core_reset_q;
  assign o_overflow          = overflow_q;
  assign o_state             = state_q;

endmodule
